// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: memop encodings, FSM states, default timeout.
package mem_stage_pkg;

    typedef enum logic [3:0] {
        MemNone = 4'd0,
        MemLw   = 4'd1,
        MemLh   = 4'd2,
        MemLhu  = 4'd3,
        MemLb   = 4'd4,
        MemLbu  = 4'd5,
        MemSw   = 4'd6,
        MemSh   = 4'd7,
        MemSb   = 4'd8
    } memop_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StDone = 2'd2
    } state_e;

    localparam int unsigned DefaultTimeout = 255;

endpackage

// File: rtl/load_align.sv
// Load lane selection and sign/zero extension of a 32-bit memory word.
module load_align
    import mem_stage_pkg::*;
(
    input  memop_e      op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] word,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte/half, then extend according to the load flavour.
    always_comb begin
        byte_sel = word[7:0];
        unique case (addr_lo)
            2'd0:    byte_sel = word[7:0];
            2'd1:    byte_sel = word[15:8];
            2'd2:    byte_sel = word[23:16];
            default: byte_sel = word[31:24];
        endcase
        half_sel = addr_lo[1] ? word[31:16] : word[15:0];

        result = 32'h0;
        unique case (op)
            MemLw:   result = word;
            MemLh:   result = {{16{half_sel[15]}}, half_sel};
            MemLhu:  result = {16'h0, half_sel};
            MemLb:   result = {{24{byte_sel[7]}}, byte_sel};
            MemLbu:  result = {24'h0, byte_sel};
            default: result = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: drives the data-memory port, stalls until ack or timeout,
// and returns the extended load result for one DONE cycle.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned TIMEOUT = DefaultTimeout
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  M_memop,
    input  logic [31:0] M_valE,
    input  logic [31:0] M_valB,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic [31:0] m_valM,
    output logic        m_stall,
    output logic        m_err
);

    localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

    memop_e      op;
    logic        is_store;
    logic        aligned;
    logic        access;
    logic        misalign;
    logic [31:0] ext;

    state_e      state_q, state_d;
    logic [31:0] hold_q, hold_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [7:0]  cnt_inc;

    // Decode the memop into store/alignment qualifiers.
    always_comb begin
        op       = memop_e'(M_memop);
        is_store = 1'b0;
        aligned  = 1'b1;
        unique case (op)
            MemLw:         aligned = (M_valE[1:0] == 2'b00);
            MemLh, MemLhu: aligned = ~M_valE[0];
            MemSw: begin
                is_store = 1'b1;
                aligned  = (M_valE[1:0] == 2'b00);
            end
            MemSh: begin
                is_store = 1'b1;
                aligned  = ~M_valE[0];
            end
            MemSb:         is_store = 1'b1;
            default:       aligned = 1'b1;
        endcase
        access   = (op != MemNone) && aligned;
        misalign = (op != MemNone) && !aligned;
    end

    // Address, store lane replication and byte enables, straight from the M register.
    always_comb begin
        dmem_addr  = {M_valE[31:2], 2'b00};
        dmem_we    = is_store;
        dmem_be    = 4'b1111;
        dmem_wdata = M_valB;
        unique case (op)
            MemSb: begin
                dmem_wdata = {4{M_valB[7:0]}};
                dmem_be    = 4'b0001 << M_valE[1:0];
            end
            MemSh: begin
                dmem_wdata = {2{M_valB[15:0]}};
                dmem_be    = 4'b0011 << M_valE[1:0];
            end
            default: ;
        endcase
    end

    load_align u_load_align (
        .op      (op),
        .addr_lo (M_valE[1:0]),
        .word    (hold_q),
        .result  (ext)
    );

    // Handshake and result outputs; misaligned ops report an error without stalling.
    always_comb begin
        dmem_req = ((state_q == StIdle) && access) || (state_q == StWait);
        m_stall  = access && (state_q != StDone);
        m_err    = misalign || ((state_q == StDone) && err_q);
        m_valM   = ((state_q == StDone) && !err_q) ? ext : 32'h0;
    end

    // Next-state logic: ack beats timeout, DONE lasts exactly one cycle.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        cnt_inc = cnt_q + 8'd1;
        unique case (state_q)
            StIdle: begin
                if (access) begin
                    if (dmem_ack) begin
                        state_d = StDone;
                        hold_d  = dmem_rdata;
                        err_d   = 1'b0;
                        cnt_d   = 8'd0;
                    end else begin
                        state_d = StWait;
                    end
                end
            end
            StWait: begin
                if (dmem_ack) begin
                    state_d = StDone;
                    hold_d  = dmem_rdata;
                    err_d   = 1'b0;
                    cnt_d   = 8'd0;
                end else if (cnt_inc == TimeoutCnt) begin
                    state_d = StDone;
                    err_d   = 1'b1;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            hold_q  <= 32'h0;
            cnt_q   <= 8'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter: TIMEOUT, default 255, number of WAIT cycles without dmem_ack before the access is aborted (range 1..255).
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 M_memop  input  4  memory operation from the M pipeline register: NONE, LW, LH, LHU, LB, LBU, SW, SH, SB.
REQ-005 M_valE  input  32  effective address for memory ops.
REQ-006 M_valB  input  32  store data.
REQ-007 dmem_req  output  1  data-memory request.
REQ-008 dmem_we  output  1  write enable for stores.
REQ-009 dmem_addr  output  32  word-aligned address: M_valE with bits [1:0] forced to 0.
REQ-010 dmem_wdata  output  32  lane-replicated store data.
REQ-011 dmem_be  output  4  byte enables, little-endian lanes.
REQ-012 dmem_rdata  input  32  read data, valid when dmem_ack=1.
REQ-013 dmem_ack  input  1  one-cycle completion strobe.
REQ-014 m_valM  output  32  extended load result, consumed by the W pipeline register.
REQ-015 m_stall  output  1  freezes the F, D, E and M stages while an access is incomplete.
REQ-016 m_err  output  1  misaligned access or timeout, valid in the cycle m_stall is low.

Function
REQ-017 The FSM SHALL have three states: IDLE, WAIT and DONE.
REQ-018 An access SHALL be defined as M_memop != NONE with correct alignment: word addr[1:0]=0, half addr[0]=0, byte any.
REQ-019 A misaligned operation SHALL issue no request, SHALL keep m_stall=0, SHALL drive m_err=1 and m_valM=0 combinationally, and SHALL leave the state in IDLE.
REQ-020 dmem_req SHALL equal (IDLE and access) or WAIT; dmem_req SHALL be 0 in DONE.
REQ-021 m_stall SHALL equal access and (state != DONE).
REQ-022 In IDLE with access and dmem_ack=1 in the same cycle, the FSM SHALL go to DONE (zero-wait case).
REQ-023 In IDLE with access and dmem_ack=0, the FSM SHALL go to WAIT.
REQ-024 In WAIT, dmem_ack=1 SHALL cause a transition to DONE.
REQ-025 In WAIT, the 8-bit wait counter SHALL increment each cycle without ack; on reaching TIMEOUT the FSM SHALL go to DONE with the error flag set.
REQ-026 If the timeout cycle and dmem_ack coincide, ack SHALL win and the error flag SHALL stay clear.
REQ-027 On the ack, the FSM SHALL latch dmem_rdata into a 32-bit hold register.
REQ-028 On the transition to DONE, the FSM SHALL clear the wait counter.
REQ-029 DONE SHALL last exactly one cycle, then the FSM SHALL return to IDLE unconditionally.
REQ-030 In DONE, m_valM SHALL be the extracted hold value (0 on timeout) and m_err SHALL be the latched error flag.
REQ-031 Load extraction: LB/LBU SHALL select byte addr[1:0], LH/LHU SHALL select half addr[1].
REQ-032 LB and LH SHALL sign-extend; LBU and LHU SHALL zero-extend; LW SHALL pass the word through unchanged.
REQ-033 Store lanes: SB SHALL drive wdata={4{b}} and be=4'b0001<<addr[1:0].
REQ-034 Store lanes: SH SHALL drive wdata={2{h}} and be=4'b0011<<addr[1:0].
REQ-035 Store lanes: SW SHALL drive be=4'b1111; loads SHALL drive be=4'b1111 and dmem_we=0.
REQ-036 For stores and NONE, m_valM SHALL be 0.
REQ-037 Address, data and control outputs SHALL be purely combinational from M_* inputs, which stay stable while stalled.

Reset
REQ-038 When rst_n is low, the block SHALL asynchronously force state=IDLE, hold=0, counter=0 and the error flag=0.
REQ-039 A reset asserted mid-WAIT SHALL abandon the access; no completion SHALL be reported after reset.

Structure
REQ-040 Memop encodings (4-bit) and the default TIMEOUT SHALL live in the shared definitions header.
REQ-041 One combinational sub-module, load_align, SHALL perform load lane selection and extension.

Verification
REQ-042 LB at addr 0x103, ack after 2 cycles with rdata 0x80FF_FF12 -> m_stall high for 3 cycles, then m_valM=0xFFFF_FF80 in DONE.
REQ-043 SH at addr 0x202 with valB 0x0000_ABCD, ack in the same cycle -> be=4'b1100, wdata=0xABCD_ABCD, we=1, m_stall=0 in the following DONE cycle.
REQ-044 LW at addr 0x006 -> dmem_req=0, m_err=1, m_stall=0, m_valM=0.
REQ-045 LHU at addr 0x0 with no ack and TIMEOUT=4 -> m_stall released after timeout, m_err=1, m_valM=0, state back in IDLE.
REQ-046 LW in WAIT with rst_n pulsed low -> outputs go to reset values immediately; a later ack is ignored with dmem_req=0.
